// File: rtl/linebuffer_scanout.sv
// linebuffer_scanout
//   Pixel-domain read stage behind the 72-bit line buffer read port. Each
//   buffer word packs 8 pixels of 9 bits, with pixel k in bits [9k+8:9k].
//   A line_start pulse selects one half of the 512-word buffer. The block
//   then issues word addresses, takes in the registered read data and emits
//   H_ACTIVE pixels back to back, one per clk_pix cycle. Pixel 0 appears 3
//   cycles after line_start is sampled, and line_done pulses in the cycle
//   after the last valid pixel.
//
// Ports
//   clk_pix      in   1  pixel clock
//   rst_pix_n    in   1  synchronous active-low reset
//   line_start   in   1  one-cycle pulse that (re)starts scanout of a line
//   line_sel     in   1  buffer half to read, sampled with line_start
//   pix_double   in   1  (only with LBSCAN_PIXEL_DOUBLE_EN) repeat each pixel twice
//   addr_pix     out  9  registered word address to the line buffer
//   colour_pix   in  72  read data, valid one cycle after addr_pix
//   pixel_out    out  9  current pixel, 0 while pixel_valid is low
//   pixel_valid  out  1  high for H_ACTIVE consecutive cycles per line
//   line_done    out  1  one-cycle pulse after the last valid pixel
//
// Optional feature macro: LBSCAN_PIXEL_DOUBLE_EN
module linebuffer_scanout #(
   parameter int H_ACTIVE   = 640,
   parameter int LINE_BASE1 = 256
) (
   input  logic        clk_pix,
   input  logic        rst_pix_n,
   input  logic        line_start,
   input  logic        line_sel,
`ifdef LBSCAN_PIXEL_DOUBLE_EN
   input  logic        pix_double,
`endif
   output logic [8:0]  addr_pix,
   input  logic [71:0] colour_pix,
   output logic [8:0]  pixel_out,
   output logic        pixel_valid,
   output logic        line_done
);

   localparam logic [8:0]  BASE1   = 9'(LINE_BASE1);
   localparam logic [8:0]  NW_1    = 9'((H_ACTIVE + 7) / 8);
   localparam logic [8:0]  NW_DBL  = 9'(((H_ACTIVE + 1) / 2 + 7) / 8);
   localparam logic [11:0] REM_INI = 12'(H_ACTIVE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      ACTIVE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t       state_q, state_d;
   logic [8:0]   base_q, base_d;
   logic         dbl_q, dbl_d;
   logic [1:0]   fph_q, fph_d;     // FETCH phase: 0 issue word 0, 1 issue word 1, 2 load
   logic [8:0]   fidx_q, fidx_d;   // next word index to fetch
   logic [8:0]   addr_q, addr_d;
   logic         rd1_q, rd1_d;     // a read was issued on the last edge
   logic         rd2_q, rd2_d;     // colour_pix holds that read's data now
   logic [71:0]  pf_q, pf_d;       // prefetched next word
   logic [71:0]  sh_q, sh_d;       // rest of the current word, next pixel in [8:0]
   logic [2:0]   pidx_q, pidx_d;   // slot of the pixel now on pixel_out
   logic         rep_q, rep_d;     // second copy of a doubled pixel
   logic [11:0]  rem_q, rem_d;     // valid cycles still to come after this one
   logic [8:0]   pix_q, pix_d;
   logic         valid_q, valid_d;
   logic         done_q, done_d;
   logic [8:0]   nwords_s;

   assign addr_pix    = addr_q;
   assign pixel_out   = pix_q;
   assign pixel_valid = valid_q;
   assign line_done   = done_q;

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n) begin
         state_q <= IDLE;    base_q <= 9'd0;   dbl_q  <= 1'b0;  fph_q  <= 2'd0;
         fidx_q  <= 9'd0;    addr_q <= 9'd0;   rd1_q  <= 1'b0;  rd2_q  <= 1'b0;
         pf_q    <= 72'd0;   sh_q   <= 72'd0;  pidx_q <= 3'd0;  rep_q  <= 1'b0;
         rem_q   <= 12'd0;   pix_q  <= 9'd0;   valid_q <= 1'b0; done_q <= 1'b0;
      end else begin
         state_q <= state_d; base_q <= base_d; dbl_q  <= dbl_d;  fph_q  <= fph_d;
         fidx_q  <= fidx_d;  addr_q <= addr_d; rd1_q  <= rd1_d;  rd2_q  <= rd2_d;
         pf_q    <= pf_d;    sh_q   <= sh_d;   pidx_q <= pidx_d; rep_q  <= rep_d;
         rem_q   <= rem_d;   pix_q  <= pix_d;  valid_q <= valid_d; done_q <= done_d;
      end
   end

   // Next-state, fetch scheduling and pixel serialisation
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      dbl_d    = dbl_q;
      fph_d    = fph_q;
      fidx_d   = fidx_q;
      addr_d   = addr_q;
      rd1_d    = 1'b0;
      rd2_d    = rd1_q;
      sh_d     = sh_q;
      pidx_d   = pidx_q;
      rep_d    = rep_q;
      rem_d    = rem_q;
      pix_d    = pix_q;
      valid_d  = valid_q;
      done_d   = 1'b0;
      nwords_s = dbl_q ? NW_DBL : NW_1;

      // Word 0 goes straight from colour_pix into the shift register at the
      // end of FETCH; every later word lands in the prefetch register.
      if (rd2_q && (state_q == ACTIVE)) begin
         pf_d = colour_pix;
      end else begin
         pf_d = pf_q;
      end

      if (line_start) begin
         // Accepted in every state; an unfinished line is dropped silently.
         state_d = FETCH;
         base_d  = line_sel ? BASE1 : 9'd0;
`ifdef LBSCAN_PIXEL_DOUBLE_EN
         dbl_d   = pix_double;
`else
         dbl_d   = 1'b0;
`endif
         fph_d   = 2'd0;
         rd1_d   = 1'b0;
         rd2_d   = 1'b0;
         pix_d   = 9'd0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               pix_d   = 9'd0;
               valid_d = 1'b0;
            end
            FETCH: begin
               case (fph_q)
                  2'd0: begin
                     addr_d = base_q;
                     fidx_d = 9'd1;
                     rd1_d  = 1'b1;
                     fph_d  = 2'd1;
                  end
                  2'd1: begin
                     if (nwords_s > 9'd1) begin
                        addr_d = base_q + 9'd1;
                        fidx_d = 9'd2;
                        rd1_d  = 1'b1;
                     end else begin
                        fidx_d = fidx_q;
                     end
                     fph_d = 2'd2;
                  end
                  default: begin
                     pix_d   = colour_pix[8:0];
                     sh_d    = {9'd0, colour_pix[71:9]};
                     pidx_d  = 3'd0;
                     rep_d   = 1'b0;
                     rem_d   = REM_INI;
                     valid_d = 1'b1;
                     state_d = ACTIVE;
                  end
               endcase
            end
            ACTIVE: begin
               if (rem_q == 12'd0) begin
                  pix_d   = 9'd0;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  rem_d = rem_q - 12'd1;
                  if (dbl_q && !rep_q) begin
                     rep_d = 1'b1;
                  end else begin
                     rep_d = 1'b0;
                     if (pidx_q == 3'd7) begin
                        // Word boundary: swap in the prefetched word and
                        // request its successor so it arrives well ahead.
                        pix_d  = pf_q[8:0];
                        sh_d   = {9'd0, pf_q[71:9]};
                        pidx_d = 3'd0;
                        if (fidx_q < nwords_s) begin
                           addr_d = base_q + fidx_q;
                           fidx_d = fidx_q + 9'd1;
                           rd1_d  = 1'b1;
                        end else begin
                           fidx_d = fidx_q;
                        end
                     end else begin
                        pix_d  = sh_q[8:0];
                        sh_d   = {9'd0, sh_q[71:9]};
                        pidx_d = pidx_q + 3'd1;
                     end
                  end
               end
            end
            DONE: begin
               pix_d   = 9'd0;
               valid_d = 1'b0;
               state_d = IDLE;
            end
            default: begin
               pix_d   = 9'd0;
               valid_d = 1'b0;
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule
